// File: rtl/rank_timing_guard.sv
// rank_timing_guard: rank-level DRAM command legality gate.
// Merges per-bank tRCD/tRP state with rank-wide tRRD/tFAW/tCCD/tWTR/tRTW/tRFC.
package rank_timing_pkg;
  typedef logic [2:0] recode_state_t;
  localparam recode_state_t CODE_ACTIVE_TO_READ_WRITE = 3'd1;
endpackage

module rank_timing_guard
  import rank_timing_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int T_RRD     = 4,
  parameter int T_FAW     = 16,
  parameter int T_CCD     = 4,
  parameter int T_WTR     = 12,
  parameter int T_RTW     = 8,
  parameter int T_RFC     = 88,
  localparam int BA_BITS  = $clog2(NUM_BANKS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue_valid,
  input  logic [2:0]                     issue_cmd,
  input  logic [BA_BITS-1:0]             issue_bank,
  input  logic [NUM_BANKS*5-1:0]         tp_cnt,
  input  recode_state_t [NUM_BANKS-1:0]  bank_recode,
  output logic [NUM_BANKS-1:0]           act_ok,
  output logic [NUM_BANKS-1:0]           rd_ok,
  output logic [NUM_BANKS-1:0]           wr_ok,
  output logic [NUM_BANKS-1:0]           pre_ok,
  output logic                           ref_ok,
  output logic [NUM_BANKS-1:0]           open_banks,
  output logic                           viol,
  output logic                           viol_sticky
);

  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_REF  = 3'd5;
  localparam logic [2:0] CMD_PREA = 3'd6;

  localparam logic [2:0] RRD_LD = 3'(T_RRD - 1);
  localparam logic [4:0] FAW_LD = 5'(T_FAW - 1);
  localparam logic [2:0] CCD_LD = 3'(T_CCD - 1);
  localparam logic [3:0] WTR_LD = 4'(T_WTR - 1);
  localparam logic [3:0] RTW_LD = 4'(T_RTW - 1);
  localparam logic [7:0] RFC_LD = 8'(T_RFC - 1);

  logic [2:0] rrd;
  logic [2:0] ccd;
  logic [3:0] wtr;
  logic [3:0] rtw;
  logic [7:0] rfc;
  logic [4:0] faw [4];
  logic [1:0] faw_ptr;

  logic cmd_act;
  logic cmd_rd;
  logic cmd_wr;
  logic cmd_pre;
  logic cmd_ref;
  logic cmd_prea;
  logic cmd_legal;

  logic [NUM_BANKS-1:0] tp_zero;
  logic [NUM_BANKS-1:0] rcd_ok;
  logic rfc_free;
  logic act_gate;
  logic rd_gate;
  logic wr_gate;

  always_comb begin
    cmd_act  = issue_valid && issue_cmd == CMD_ACT;
    cmd_rd   = issue_valid && issue_cmd == CMD_RD;
    cmd_wr   = issue_valid && issue_cmd == CMD_WR;
    cmd_pre  = issue_valid && issue_cmd == CMD_PRE;
    cmd_ref  = issue_valid && issue_cmd == CMD_REF;
    cmd_prea = issue_valid && issue_cmd == CMD_PREA;
  end

  // tRCD only gates column commands while the bank is still opening
  always_comb begin
    tp_zero = '0;
    rcd_ok  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      tp_zero[b] = tp_cnt[5*b +: 5] == 5'd0;
      rcd_ok[b]  = (bank_recode[b] != CODE_ACTIVE_TO_READ_WRITE)
                   || tp_zero[b];
    end
  end

  assign rfc_free = rfc == 8'd0;
  assign act_gate = rrd == 3'd0 && faw[faw_ptr] == 5'd0 && rfc_free;
  assign rd_gate  = ccd == 3'd0 && wtr == 4'd0 && rfc_free;
  assign wr_gate  = ccd == 3'd0 && rtw == 4'd0 && rfc_free;

  assign act_ok = ~open_banks & tp_zero & {NUM_BANKS{act_gate}};
  assign rd_ok  = open_banks & rcd_ok & {NUM_BANKS{rd_gate}};
  assign wr_ok  = open_banks & rcd_ok & {NUM_BANKS{wr_gate}};
  assign pre_ok = tp_zero & {NUM_BANKS{rfc_free}};
  assign ref_ok = open_banks == '0 && &tp_zero && rfc_free;

  always_comb begin
    cmd_legal = 1'b1;
    unique case (1'b1)
      cmd_act:  cmd_legal = act_ok[issue_bank];
      cmd_rd:   cmd_legal = rd_ok[issue_bank];
      cmd_wr:   cmd_legal = wr_ok[issue_bank];
      cmd_pre:  cmd_legal = pre_ok[issue_bank];
      cmd_ref:  cmd_legal = ref_ok;
      cmd_prea: cmd_legal = &pre_ok;
      default:  cmd_legal = 1'b1;
    endcase
  end

  // state tracks what was driven on the bus, legal or not
  always_ff @(posedge clk) begin
    if (rst) begin
      rrd         <= '0;
      ccd         <= '0;
      wtr         <= '0;
      rtw         <= '0;
      rfc         <= '0;
      faw_ptr     <= '0;
      open_banks  <= '0;
      viol        <= 1'b0;
      viol_sticky <= 1'b0;
      for (int i = 0; i < 4; i++) faw[i] <= '0;
    end else begin
      rrd <= cmd_act ? RRD_LD
           : (rrd != 3'd0 ? rrd - 3'd1 : 3'd0);
      ccd <= (cmd_rd || cmd_wr) ? CCD_LD
           : (ccd != 3'd0 ? ccd - 3'd1 : 3'd0);
      wtr <= cmd_wr ? WTR_LD
           : (wtr != 4'd0 ? wtr - 4'd1 : 4'd0);
      rtw <= cmd_rd ? RTW_LD
           : (rtw != 4'd0 ? rtw - 4'd1 : 4'd0);
      rfc <= cmd_ref ? RFC_LD
           : (rfc != 8'd0 ? rfc - 8'd1 : 8'd0);
      for (int i = 0; i < 4; i++)
        faw[i] <= (cmd_act && faw_ptr == 2'(i)) ? FAW_LD
                : (faw[i] != 5'd0 ? faw[i] - 5'd1 : 5'd0);
      if (cmd_act) faw_ptr <= faw_ptr + 2'd1;
      if (cmd_prea) open_banks <= '0;
      else if (cmd_act) open_banks[issue_bank] <= 1'b1;
      else if (cmd_pre) open_banks[issue_bank] <= 1'b0;
      viol        <= issue_valid && !cmd_legal;
      viol_sticky <= viol_sticky | viol;
    end
  end

endmodule

// File: tb/tb_rank_timing_guard.sv
// Directed bench for rank_timing_guard.
// Default timing: tRRD 4, tFAW 16, tCCD 4, tWTR 12, tRTW 8, tRFC 88.
module tb_rank_timing_guard;
  import rank_timing_pkg::*;

  localparam logic [2:0] ACT  = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] REF  = 3'd5;
  localparam logic [2:0] PREA = 3'd6;

  logic                clk;
  logic                rst;
  logic                issue_valid;
  logic [2:0]          issue_cmd;
  logic [2:0]          issue_bank;
  logic [39:0]         tp_cnt;
  recode_state_t [7:0] bank_recode;
  logic [7:0]          act_ok;
  logic [7:0]          rd_ok;
  logic [7:0]          wr_ok;
  logic [7:0]          pre_ok;
  logic                ref_ok;
  logic [7:0]          open_banks;
  logic                viol;
  logic                viol_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  rank_timing_guard dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_cmd   (issue_cmd),
    .issue_bank  (issue_bank),
    .tp_cnt      (tp_cnt),
    .bank_recode (bank_recode),
    .act_ok      (act_ok),
    .rd_ok       (rd_ok),
    .wr_ok       (wr_ok),
    .pre_ok      (pre_ok),
    .ref_ok      (ref_ok),
    .open_banks  (open_banks),
    .viol        (viol),
    .viol_sticky (viol_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    issue_cmd   = 3'd0;
  endtask

  task automatic issue(input logic [2:0] c, input int b);
    issue_valid = 1'b1;
    issue_cmd   = c;
    issue_bank  = 3'(b);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    issue_valid = 1'b0;
    issue_cmd   = 3'd0;
    issue_bank  = 3'd0;
    tp_cnt      = '0;
    bank_recode = '0;
    do_reset();

    chk("rst_act", 32'(act_ok), 32'hFF);
    chk("rst_rd", 32'(rd_ok), 32'h00);
    chk("rst_wr", 32'(wr_ok), 32'h00);
    chk("rst_pre", 32'(pre_ok), 32'hFF);
    chk("rst_ref", 32'(ref_ok), 32'd1);
    chk("rst_open", 32'(open_banks), 32'h00);
    chk("rst_viol", 32'(viol), 32'd0);
    chk("rst_sticky", 32'(viol_sticky), 32'd0);

    tp_cnt[15 +: 5] = 5'd2;
    #1;
    chk("tp_act", 32'(act_ok), 32'hF7);
    chk("tp_pre", 32'(pre_ok), 32'hF7);
    chk("tp_ref", 32'(ref_ok), 32'd0);
    tp_cnt = '0;
    #1;

    issue(ACT, 0);
    chk("rrd_open", 32'(open_banks), 32'h01);
    chk("rrd_viol", 32'(viol), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      chk("rrd_blk", 32'(act_ok[1]), 32'd0);
      tick();
    end
    chk("rrd_ok", 32'(act_ok), 32'hFE);
    chk("rd_open", 32'(rd_ok), 32'h01);

    issue(WR, 0);
    chk("wr_ccd", 32'(wr_ok), 32'h00);
    chk("wr_wtr", 32'(rd_ok), 32'h00);
    for (int k = 1; k <= 3; k++) begin
      chk("ccd_blk", 32'(wr_ok[0]), 32'd0);
      tick();
    end
    chk("ccd_ok", 32'(wr_ok), 32'h01);
    chk("wtr_blk4", 32'(rd_ok), 32'h00);
    repeat (7) tick();
    chk("wtr_blk11", 32'(rd_ok), 32'h00);
    tick();
    chk("wtr_ok", 32'(rd_ok), 32'h01);

    issue(RD, 0);
    chk("rd_ccd", 32'(rd_ok), 32'h00);
    chk("rtw_blk1", 32'(wr_ok), 32'h00);
    repeat (3) tick();
    chk("rd_ccd_ok", 32'(rd_ok), 32'h01);
    chk("rtw_blk4", 32'(wr_ok), 32'h00);
    repeat (3) tick();
    chk("rtw_blk7", 32'(wr_ok), 32'h00);
    tick();
    chk("rtw_ok", 32'(wr_ok), 32'h01);

    bank_recode[0] = CODE_ACTIVE_TO_READ_WRITE;
    tp_cnt[0 +: 5] = 5'd3;
    #1;
    chk("rcd_rd", 32'(rd_ok), 32'h00);
    chk("rcd_wr", 32'(wr_ok), 32'h00);
    chk("rcd_pre", 32'(pre_ok), 32'hFE);
    bank_recode = '0;
    #1;
    chk("rcd_other", 32'(rd_ok), 32'h01);
    tp_cnt = '0;
    #1;
    chk("clean_sticky", 32'(viol_sticky), 32'd0);

    chk("ref_open", 32'(ref_ok), 32'd0);
    issue(PREA, 0);
    chk("prea_open", 32'(open_banks), 32'h00);
    chk("prea_ref", 32'(ref_ok), 32'd1);
    issue(REF, 0);
    chk("rfc_act", 32'(act_ok), 32'h00);
    chk("rfc_pre", 32'(pre_ok), 32'h00);
    chk("rfc_ref", 32'(ref_ok), 32'd0);
    chk("rfc_viol", 32'(viol), 32'd0);
    repeat (86) tick();
    chk("rfc_blk87", 32'(act_ok), 32'h00);
    tick();
    chk("rfc_act_ok", 32'(act_ok), 32'hFF);
    chk("rfc_ref_ok", 32'(ref_ok), 32'd1);
    chk("rfc_sticky", 32'(viol_sticky), 32'd0);

    do_reset();
    issue(ACT, 0);
    chk("v_first", 32'(viol), 32'd0);
    issue(ACT, 1);
    chk("v_b1", 32'(viol), 32'd1);
    chk("v_sticky_lag", 32'(viol_sticky), 32'd0);
    issue(ACT, 2);
    chk("v_b2", 32'(viol), 32'd1);
    chk("v_sticky", 32'(viol_sticky), 32'd1);
    issue(ACT, 3);
    chk("v_b3", 32'(viol), 32'd1);
    tick();
    chk("v_clear", 32'(viol), 32'd0);
    chk("v_hold", 32'(viol_sticky), 32'd1);
    chk("faw_open", 32'(open_banks), 32'h0F);
    repeat (10) tick();
    chk("faw_blk", 32'(act_ok), 32'h00);
    tick();
    chk("faw_ok", 32'(act_ok), 32'hF0);

    issue(ACT, 4);
    chk("faw5_viol", 32'(viol), 32'd0);
    chk("faw5_act", 32'(act_ok), 32'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_sticky", 32'(viol_sticky), 32'd0);
    chk("mid_open", 32'(open_banks), 32'h00);
    chk("mid_act", 32'(act_ok), 32'hFF);
    chk("mid_ref", 32'(ref_ok), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
